// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared constants and types for the pipe_MIPS32 program loader:
//   - 6-bit opcode constants and the HLT instruction word
//   - loader FSM state encoding
//   - byte/word geometry for the byte packer
// No ports (package).
// -----------------------------------------------------------------------------
package mips32_pkg;

    localparam int unsigned INSN_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 2;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h0a;
    localparam logic [5:0] OP_HLT  = 6'h3f;

    localparam logic [INSN_W-1:0] HLT_WORD = {OP_HLT, 26'd0};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        START   = 3'd3,
        RUN     = 3'd4
    } loader_state_e;

endpackage

// File: rtl/mips_byte_packer.sv
// -----------------------------------------------------------------------------
// mips_byte_packer
// Assembles big-endian 32-bit words from a byte stream. The first byte of a
// word lands in bits [31:24]. When the 4th byte is taken the full word is
// registered on word_data and word_valid pulses for one cycle. load_hlt
// overwrites the word with the HLT instruction and pulses word_valid.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          drop any partially collected word (index back to 0)
//   byte_en        take byte_data this cycle
//   byte_data      8-bit input byte
//   load_hlt       present HLT_WORD as the next word
//   byte_idx       index of the next byte within the word (0..3)
//   word_valid     one-cycle pulse, word_data holds a complete word
//   word_data      last completed word
// -----------------------------------------------------------------------------
module mips_byte_packer
    import mips32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              load_hlt,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              word_valid,
    output logic [INSN_W-1:0] word_data
);

    localparam int unsigned SHIFT_W = INSN_W - BYTE_W;

    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [INSN_W-1:0]  word_q,  word_d;
    logic               valid_q, valid_d;
    logic               last_byte_c;

    // Byte index / shift register update
    always_comb begin
        idx_d       = idx_q;
        shift_d     = shift_q;
        word_d      = word_q;
        valid_d     = 1'b0;
        last_byte_c = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

        if (clear) begin
            idx_d = '0;
        end else if (byte_en) begin
            // index wraps 3 -> 0 naturally at IDX_W bits
            idx_d   = idx_q + IDX_W'(1);
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_data};
            if (last_byte_c) begin
                word_d  = {shift_q, byte_data};
                valid_d = 1'b1;
            end
        end

        if (load_hlt) begin
            word_d  = HLT_WORD;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign byte_idx   = idx_q;
    assign word_valid = valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/mips_prog_loader.sv
// -----------------------------------------------------------------------------
// mips_prog_loader
// Boot-time program loader for pipe_MIPS32. Takes a byte stream over
// valid/ready, packs big-endian instruction words, writes them to instruction
// memory from word address 0, then releases the core with a one-cycle start
// pulse and flags done when the core reports HALTED.
// Build option: define HALT_APPEND_EN to append an HLT word after the last
// program word (word_count includes it).
// Ports:
//   clk1, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data    byte stream handshake, MSB byte of a word first
//   s_last                    marks the final program byte
//   mem_we/mem_addr/mem_wdata instruction memory write port (one cycle per word)
//   core_hold                 keeps the core idle while high
//   core_start                one-cycle release pulse
//   core_halted               core HALTED flag
//   busy                      FSM not in IDLE
//   done, err                 sticky completion / abort flags
//   word_count                words written in the current or last load
// -----------------------------------------------------------------------------
module mips_prog_loader
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic              s_ready_q, s_ready_d;
    logic              core_hold_q, core_hold_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
`ifdef HALT_APPEND_EN
    logic              hlt_pend_q, hlt_pend_d;
`endif

    logic              accept_c;
    logic              word_done_c;
    logic              pk_clear_c;
    logic              pk_byte_en_c;
    logic              pk_load_hlt_c;
    logic [IDX_W-1:0]  pk_idx;
    logic              pk_valid;
    logic [INSN_W-1:0] pk_word;

    assign accept_c    = s_valid && s_ready_q;
    assign word_done_c = accept_c && (pk_idx == IDX_W'(BYTES_PER_WORD - 1));

    // Byte assembly; its registered word/valid drive the memory port directly
    mips_byte_packer u_packer (
        .clk        (clk1),
        .rst        (rst),
        .clear      (pk_clear_c),
        .byte_en    (pk_byte_en_c),
        .byte_data  (s_data),
        .load_hlt   (pk_load_hlt_c),
        .byte_idx   (pk_idx),
        .word_valid (pk_valid),
        .word_data  (pk_word)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wc_d          = wc_q;
        done_d        = done_q;
        err_d         = err_q;
        last_d        = last_q;
        pk_clear_c    = 1'b0;
        pk_byte_en_c  = 1'b0;
        pk_load_hlt_c = 1'b0;
`ifdef HALT_APPEND_EN
        hlt_pend_d    = hlt_pend_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    wc_d   = '0;
                    addr_d = '0;
                    if (s_last) begin
                        // single-byte program: partial word
                        err_d = 1'b1;
                    end else begin
                        pk_byte_en_c = 1'b1;
                        state_d      = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (accept_c) begin
                    if (wc_q == DEPTH) begin
                        // memory full: reject byte, no wrap
                        err_d      = 1'b1;
                        pk_clear_c = 1'b1;
                        state_d    = IDLE;
                    end else if (word_done_c) begin
                        pk_byte_en_c = 1'b1;
                        last_d       = s_last;
                        state_d      = WRITE;
                    end else if (s_last) begin
                        err_d      = 1'b1;
                        pk_clear_c = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        pk_byte_en_c = 1'b1;
                    end
                end
            end

            WRITE: begin
                // address saturates so an overflowing load never wraps to 0
                addr_d = (addr_q == '1) ? addr_q : addr_q + ADDR_W'(1);
                wc_d   = wc_q + CNT_W'(1);
                if (!last_q) begin
                    state_d = COLLECT;
`ifdef HALT_APPEND_EN
                end else if (hlt_pend_q) begin
                    hlt_pend_d = 1'b0;
                    state_d    = START;
                end else if (wc_d == DEPTH) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    hlt_pend_d    = 1'b1;
                    pk_load_hlt_c = 1'b1;
                    state_d       = WRITE;
                end
`else
                end else begin
                    state_d = START;
                end
`endif
            end

            START: begin
                state_d = RUN;
            end

            RUN: begin
                if (core_halted) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d    = (state_d == IDLE) || (state_d == COLLECT);
        core_start_d = (state_d == START);
        core_hold_d  = !((state_d == START) || (state_d == RUN));
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wc_q         <= '0;
            s_ready_q    <= 1'b1;
            core_hold_q  <= 1'b1;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= 1'b0;
`ifdef HALT_APPEND_EN
            hlt_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wc_q         <= wc_d;
            s_ready_q    <= s_ready_d;
            core_hold_q  <= core_hold_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            last_q       <= last_d;
`ifdef HALT_APPEND_EN
            hlt_pend_q   <= hlt_pend_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = pk_valid;
    assign mem_addr   = addr_q;
    assign mem_wdata  = pk_word;
    assign core_hold  = core_hold_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_mips_prog_loader
// Randomized bench for the program loader with a word-level reference model.
// Uses a small memory (ADDR_W=2, four words) so overflow is reachable.
// -----------------------------------------------------------------------------
module tb_mips_prog_loader;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] HLT    = 32'hfc00_0000;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h00;
    logic              s_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              core_start;
    logic              core_halted = 1'b1;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    always #5 clk1 = ~clk1;

    mips_prog_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_hold   (core_hold),
        .core_start  (core_start),
        .core_halted (core_halted),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed memory writes and start pulses
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          start_cnt = 0;

    always @(negedge clk1) begin
        if (!rst && mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (!rst && core_start) start_cnt++;
    end

    logic [7:0] prog[$];

    task automatic check_reset(input string tag);
        check_val({tag, "_s_ready"},    32'(s_ready),    32'd1);
        check_val({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check_val({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check_val({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check_val({tag, "_core_hold"},  32'(core_hold),  32'd1);
        check_val({tag, "_core_start"}, 32'(core_start), 32'd0);
        check_val({tag, "_busy"},       32'(busy),       32'd0);
        check_val({tag, "_done"},       32'(done),       32'd0);
        check_val({tag, "_err"},        32'(err),        32'd0);
        check_val({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // Drive prog[0..n_send-1]; mode 0 = back-to-back, 1 = every other cycle, 2 = random gaps
    task automatic send_bytes(input string tag, input int n_send, input int mode);
        int  i     = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        bit  want;
        bit  acc;
        while (i < n_send && guard < 400) begin
            if (!s_valid) begin
                case (mode)
                    0:       want = 1'b1;
                    1:       want = phase;
                    default: want = ($urandom_range(0, 2) != 0);
                endcase
                phase = !phase;
                if (want) begin
                    s_valid = 1'b1;
                    s_data  = prog[i];
                    s_last  = (i == prog.size() - 1);
                end
            end
            acc = s_valid && s_ready;
            @(posedge clk1);
            @(negedge clk1);
            if (acc) begin
                i++;
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_val({tag, "_bytes_taken"}, 32'(i), 32'(n_send));
    endtask

    task automatic run_load(input string tag, input int mode);
        int          n = prog.size();
        int          n_send;
        int          n_words;
        bit          exp_err;
        bit          exp_start;
        logic [31:0] exp_w[$];
        int          w0 = wr_data_q.size();
        int          s0 = start_cnt;
        int          n_got;

        // Reference: whole words are written; stream beyond memory or a ragged tail is an error
        if (n > 4 * DEPTH) begin
            n_send  = 4 * DEPTH + 1;
            n_words = DEPTH;
            exp_err = 1'b1;
        end else begin
            n_send  = n;
            n_words = n / 4;
            exp_err = (n % 4) != 0;
        end
        for (int k = 0; k < n_words; k++)
            exp_w.push_back({prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]});
        exp_start = !exp_err;
`ifdef HALT_APPEND_EN
        if (!exp_err) begin
            if (n_words < DEPTH) exp_w.push_back(HLT);
            else begin
                exp_err   = 1'b1;
                exp_start = 1'b0;
            end
        end
`endif

        core_halted = 1'b1;
        send_bytes(tag, n_send, mode);

        // Let the write(s) and start sequence play out; core drops HALTED when started
        for (int c = 0; c < 6; c++) begin
            @(negedge clk1);
            if (core_start) core_halted = 1'b0;
        end

        n_got = wr_data_q.size() - w0;
        check_val({tag, "_nwrites"}, 32'(n_got), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < n_got; k++) begin
            check_val($sformatf("%s_addr%0d", tag, k), 32'(wr_addr_q[w0+k]), 32'(k));
            check_val($sformatf("%s_data%0d", tag, k), wr_data_q[w0+k], exp_w[k]);
        end
        check_val({tag, "_word_count"}, 32'(word_count), 32'(exp_w.size()));
        check_val({tag, "_err"},        32'(err),        32'(exp_err));
        check_val({tag, "_starts"},     32'(start_cnt - s0), 32'(exp_start));
        check_val({tag, "_core_hold"},  32'(core_hold),  32'(!exp_start));
        check_val({tag, "_busy"},       32'(busy),       32'(exp_start));
        check_val({tag, "_s_ready"},    32'(s_ready),    32'(!exp_start));
        check_val({tag, "_done_early"}, 32'(done),       32'd0);

        if (exp_start) begin
            repeat ($urandom_range(0, 5)) @(negedge clk1);
            core_halted = 1'b1;
            for (int c = 0; c < 10 && !done; c++) @(negedge clk1);
            check_val({tag, "_done"},      32'(done),      32'd1);
            check_val({tag, "_hold_back"}, 32'(core_hold), 32'd1);
            check_val({tag, "_idle"},      32'(busy),      32'd0);
            check_val({tag, "_err_run"},   32'(err),       32'd0);
        end
        repeat (2) @(negedge clk1);
    endtask

    task automatic load_bytes(input logic [7:0] b[$]);
        prog.delete();
        foreach (b[k]) prog.push_back(b[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        repeat (3) @(negedge clk1);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk1);

        load_bytes('{8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02, 8'h00, 8'h14,
                     8'hfc, 8'h00, 8'h00, 8'h00});
        run_load("prog3", 0);
        run_load("prog3_alt", 1);

        load_bytes('{8'h28, 8'h01, 8'h00, 8'h0a, 8'h28, 8'h02});
        run_load("partial", 2);

        prog.delete();
        repeat (20) prog.push_back(8'($urandom));
        run_load("overflow", 0);

        load_bytes('{8'h00, 8'h22, 8'h20, 8'h00});
        run_load("single", 2);

        // Reset while word 1 (address 1) is being written
        prog.delete();
        repeat (12) prog.push_back(8'($urandom));
        send_bytes("rst_pre", 8, 0);
        check_val("rst_mid_we",   32'(mem_we),   32'd1);
        check_val("rst_mid_addr", 32'(mem_addr), 32'd1);
        rst = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        check_reset("rst_mid");
        rst = 1'b0;
        @(negedge clk1);
        prog.delete();
        repeat (8) prog.push_back(8'($urandom));
        run_load("after_rst", 2);

        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      n = 4 * $urandom_range(1, DEPTH);
            else if (r < 8) n = $urandom_range(1, 4 * DEPTH);
            else            n = $urandom_range(4 * DEPTH + 1, 4 * DEPTH + 8);
            prog.delete();
            repeat (n) prog.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Hardware program loader for pipe_MIPS32. It is the writer side of the instruction-memory/boot interface that benches currently drive by hierarchical poke. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially from address 0. It then releases the core with a one-cycle start pulse and reports completion when the core raises HALTED.

Parameters:
ADDR_W, 10, instruction memory word-address width (depth 2^ADDR_W)
WORD_W, 32, instruction word width; fixed at 32, present for package consistency

Ports:
clk1  in  1  single clock (core phase-1 clock domain)
rst  in  1  synchronous active-high reset
s_valid  in  1  input byte valid
s_ready  out  1  loader can accept a byte this cycle
s_data  in  8  program byte, most-significant byte of each word first
s_last  in  1  qualifies the final byte of the program
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  word address of the write
mem_wdata  out  32  assembled instruction word
core_hold  out  1  holds the core idle (PC=0, HALTED=1, TAKEN_BRANCH=0) while high
core_start  out  1  one-cycle pulse that releases the core from PC 0
core_halted  in  1  core HALTED flag
busy  out  1  high in any state other than IDLE
done  out  1  sticky: program ran to HLT; cleared by the next accepted byte or by rst
err  out  1  sticky: load aborted; cleared by the next accepted byte or by rst
word_count  out  ADDR_W+1  number of words written in the current or last load

Behaviour:
- Reset values: s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, busy=0, done=0, err=0, word_count=0. The FSM enters IDLE.
- States:
  - IDLE: s_ready=1. The first accepted byte clears done/err and word_count, then moves to COLLECT.
  - COLLECT: accept bytes; byte index 0..3 shifts into bits [31:24], [23:16], [15:8], [7:0]. The 4th byte moves to WRITE.
  - WRITE: s_ready=0, mem_we=1 for exactly one cycle with the current mem_addr. mem_addr and word_count increment on the following edge. If the word carried s_last, go to START; otherwise return to COLLECT.
  - START: s_ready=0, core_hold drops and core_start=1 for one cycle, then move to RUN.
  - RUN: s_ready=0. Wait for core_halted=1, then set done=1, assert core_hold=1, and return to IDLE.
- A byte is accepted only when s_valid&&s_ready. At most one byte is accepted per cycle, so the minimum word period is 5 cycles (4 bytes + 1 write cycle).
- Partial word: if s_last arrives on byte index 0..2, no write occurs, err=1, and the FSM returns to IDLE with core_hold=1.
- Overflow: a byte accepted after 2^ADDR_W words have been written sets err=1 and returns to IDLE. Memory is not written and the address does not wrap.
- core_halted during COLLECT/WRITE is ignored, because the core is held.
- rst mid-load or mid-run: immediate return to reset values. Memory already written is left as is.
- s_valid while s_ready=0: the byte must be held by the source; the loader does not drop it.

Optional Feature:
HALT_APPEND_EN
- Defined: after the s_last word, the FSM inserts one extra WRITE of 32'hfc000000 (HLT) at the next address before START. word_count includes it. If that address would overflow, err=1 and START is skipped.
- Undefined: the program must supply its own HLT, and START follows the last word directly.

Decomposition:
- Package mips32_pkg holds:
  - opcode constants (ADD, ADDI, OR, HLT=6'h3f) and HLT_WORD=32'hfc000000
  - the loader state enum (IDLE, COLLECT, WRITE, START, RUN)
  - the BYTES_PER_WORD=4 constant
- One natural sub-module, mips_byte_packer: byte index counter plus shift register, with outputs word_valid and word_data. The FSM and address/handshake logic stay in the top.

Test Plan:
- Stream bytes 28 01 00 0a / 28 02 00 14 / fc 00 00 00 (s_last on the final byte) -> mem writes at addr 0,1,2 of 2801000a, 28020014, fc000000; word_count=3; one core_start pulse; done=1 after core_halted.
- Same program with s_valid toggled every other cycle -> identical writes and data; no byte is lost or duplicated.
- s_last on the 2nd byte of word 1 -> exactly one write (addr 0), err=1, no core_start, core_hold stays 1.
- ADDR_W=2, stream 5 words -> 4 writes to addresses 0..3, err=1 on the 17th byte, no address wrap.
- Assert rst during WRITE of word 2 -> next cycle all outputs at reset values; a fresh load restarts at addr 0.
- With HALT_APPEND_EN, stream 00222000 only -> writes 00222000 at 0 and fc000000 at 1; word_count=2; then core_start.
